// File: rtl/cpu_wb_pkg.sv
// Shared types for the register-file writeback arbiter: writeback requests and
// multiplier-queue entries, sized from the global CPU register geometry.
package cpu_wb_pkg;
    localparam int unsigned CPU_REG_WIDTH = 32;
    localparam int unsigned CPU_NUM_REGS  = 32;
    localparam int unsigned CPU_ADDR_W    = $clog2(CPU_NUM_REGS);

    typedef struct packed {
        logic                     we;
        logic [CPU_ADDR_W-1:0]    rd;
        logic [CPU_REG_WIDTH-1:0] data;
    } wb_req_t;

    typedef struct packed {
        logic                     valid;
        logic                     live;
        logic [CPU_ADDR_W-1:0]    rd;
        logic [CPU_REG_WIDTH-1:0] data;
    } wb_qentry_t;

    function automatic logic [CPU_NUM_REGS-1:0] rd_onehot(input logic [CPU_ADDR_W-1:0] rd);
        rd_onehot     = '0;
        rd_onehot[rd] = 1'b1;
    endfunction
endpackage

// File: rtl/cpu_wb_arbiter_if.sv
// Writeback arbiter bus: ALU and multiplier producers in, register-file port
// and hazard-tracking status out.
interface cpu_wb_arbiter_if #(
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned DEPTH     = 2
);
    localparam int unsigned ADDR_W = $clog2(NUM_REGS);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic                 alu_we;
    logic [ADDR_W-1:0]    alu_rd;
    logic [REG_WIDTH-1:0] alu_data;
    logic                 mul_valid;
    logic [ADDR_W-1:0]    mul_rd;
    logic [REG_WIDTH-1:0] mul_data;
    logic                 mul_ready;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_reg;
    logic [REG_WIDTH-1:0] wr_data;
    logic [NUM_REGS-1:0]  pending_mask;
    logic [CNT_W-1:0]     queue_count;

    modport master (
        output alu_we, alu_rd, alu_data, mul_valid, mul_rd, mul_data,
        input  mul_ready, wr_en, wr_reg, wr_data, pending_mask, queue_count
    );

    modport slave (
        input  alu_we, alu_rd, alu_data, mul_valid, mul_rd, mul_data,
        output mul_ready, wr_en, wr_reg, wr_data, pending_mask, queue_count
    );
endinterface

// File: rtl/cpu_wb_queue.sv
// In-order multiplier result queue with tag-match kill; killed entries keep
// their slot until popped so ordering and occupancy stay simple.
module cpu_wb_queue
    import cpu_wb_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push_en,
    input  logic                     i_push_live,
    input  logic [CPU_ADDR_W-1:0]    i_push_rd,
    input  logic [CPU_REG_WIDTH-1:0] i_push_data,
    input  logic                     i_pop_en,
    input  logic                     i_kill_en,
    input  logic [CPU_ADDR_W-1:0]    i_kill_rd,
    output wb_qentry_t               o_head,
    output logic [CNT_W-1:0]         o_count,
    output logic [CPU_NUM_REGS-1:0]  o_live_mask
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_qentry_t              r_q [DEPTH];
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [CNT_W-1:0]        r_count;
    logic [CPU_NUM_REGS-1:0] w_mask;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q      <= '{default: '0};
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (i_kill_en && r_q[i].valid && r_q[i].live && r_q[i].rd == i_kill_rd)
                    r_q[i].live <= 1'b0;
            end
            if (i_pop_en) begin
                r_q[r_rd_ptr].valid <= 1'b0;
                r_q[r_rd_ptr].live  <= 1'b0;
                r_rd_ptr            <= ptr_next(r_rd_ptr);
            end
            if (i_push_en) begin
                r_q[r_wr_ptr] <= '{valid: 1'b1, live: i_push_live, rd: i_push_rd, data: i_push_data};
                r_wr_ptr      <= ptr_next(r_wr_ptr);
            end
            r_count <= r_count + CNT_W'(i_push_en) - CNT_W'(i_pop_en);
        end
    end

    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_q[i].valid && r_q[i].live)
                w_mask = w_mask | rd_onehot(r_q[i].rd);
        end
    end

    assign o_head      = r_q[r_rd_ptr];
    assign o_count     = r_count;
    assign o_live_mask = w_mask;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push_en && r_count == CNT_W'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_pop_en && r_count == '0));
endmodule

// File: rtl/cpu_wb_arbiter.sv
// Register-file write port arbiter: ALU writes always win, multiplier results
// queue behind them and drain on ALU-idle cycles; stale queued results are killed.
module cpu_wb_arbiter
    import cpu_wb_pkg::*;
#(
    parameter int unsigned REG_WIDTH = CPU_REG_WIDTH,
    parameter int unsigned NUM_REGS  = CPU_NUM_REGS,
    parameter int unsigned DEPTH     = 2
) (
    input  logic              clock,
    input  logic              reset,
    cpu_wb_arbiter_if.slave   bus
);
    localparam int unsigned ADDR_W = $clog2(NUM_REGS);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    wb_qentry_t           w_head;
    logic [CNT_W-1:0]     w_count;
    logic                 w_full;
    logic                 w_xfer;
    logic                 w_pop;
    logic                 w_bypass;
    logic                 w_push;
    logic                 w_push_live;
    wb_req_t              w_sel;

    logic                 r_wr_en;
    logic [ADDR_W-1:0]    r_wr_reg;
    logic [REG_WIDTH-1:0] r_wr_data;

    assign w_full        = (w_count == CNT_W'(DEPTH));
    assign bus.mul_ready = reset && !w_full;
    assign w_xfer        = bus.mul_valid && bus.mul_ready;

    // Head valid doubles as "queue non-empty"; a killed head pops with we=0.
    always_comb begin
        w_sel    = '0;
        w_pop    = 1'b0;
        w_bypass = 1'b0;
        if (bus.alu_we) begin
            w_sel = '{we: 1'b1, rd: bus.alu_rd, data: bus.alu_data};
        end else if (w_head.valid) begin
            w_pop = 1'b1;
            w_sel = '{we: w_head.live, rd: w_head.rd, data: w_head.data};
        end else if (w_xfer) begin
            w_bypass = 1'b1;
            w_sel    = '{we: 1'b1, rd: bus.mul_rd, data: bus.mul_data};
        end
    end

    assign w_push      = w_xfer && !w_bypass;
    assign w_push_live = !(bus.alu_we && bus.mul_rd == bus.alu_rd);

    cpu_wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk         (clock),
        .rst_n       (reset),
        .i_push_en   (w_push),
        .i_push_live (w_push_live),
        .i_push_rd   (bus.mul_rd),
        .i_push_data (bus.mul_data),
        .i_pop_en    (w_pop),
        .i_kill_en   (bus.alu_we),
        .i_kill_rd   (bus.alu_rd),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_live_mask (bus.pending_mask)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_en   <= 1'b0;
            r_wr_reg  <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_sel.we;
            if (w_sel.we) begin
                r_wr_reg  <= w_sel.rd;
                r_wr_data <= w_sel.data;
            end
        end
    end

    assign bus.wr_en       = r_wr_en;
    assign bus.wr_reg      = r_wr_reg;
    assign bus.wr_data     = r_wr_data;
    assign bus.queue_count = w_count;
endmodule
